// File: rtl/ex_mem_stage.sv
// EX/MEM boundary register with a 2-entry skid buffer, registered in_ready and beq resolution.
// Define EX_MEM_FWD_EN to add the fwd_valid/fwd_rd/fwd_data forwarding taps from the head entry.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_store_data,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic                  in_is_branch,
  input  logic [DATA_W-1:0]     in_branch_target,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic                  out_zero,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target
`ifdef EX_MEM_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  localparam int ENT_W = 2 * DATA_W + REG_ADDR_W + CTRL_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ENT_W-1:0] head_r;
  logic [ENT_W-1:0] skid_r;
  logic [ENT_W-1:0] in_entry_s;
  logic             accept_s;
  logic             pop_s;
  logic             br_fire_s;

  assign in_entry_s = {alu_result, alu_zero, in_rd, in_store_data, in_ctrl};
  assign accept_s   = in_valid & in_ready;
  assign pop_s      = out_valid & out_ready;
  // A branch accepted in a flush cycle is dropped along with its entry.
  assign br_fire_s  = accept_s & ~flush & in_is_branch & alu_zero;

  assign {out_result, out_zero, out_rd, out_store_data, out_ctrl} = head_r;

`ifdef EX_MEM_FWD_EN
  assign fwd_valid = out_valid & out_ctrl[2] & (out_rd != {REG_ADDR_W{1'b0}});
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
`endif

  // Occupancy transitions of the skid buffer; flush overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) state_nxt_s = ONE;
          else          state_nxt_s = EMPTY;
        end
        ONE: begin
          if (accept_s && !pop_s)      state_nxt_s = FULL;
          else if (!accept_s && pop_s) state_nxt_s = EMPTY;
          else                         state_nxt_s = ONE;
        end
        FULL: begin
          if (pop_s) state_nxt_s = ONE;
          else       state_nxt_s = FULL;
        end
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // State, handshake flags, entry storage and branch pulse; ready/valid derive from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= EMPTY;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      head_r        <= {ENT_W{1'b0}};
      skid_r        <= {ENT_W{1'b0}};
      branch_taken  <= 1'b0;
      branch_target <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      in_ready  <= (state_nxt_s != FULL);
      out_valid <= (state_nxt_s != EMPTY);
      if (flush) begin
        // Zeroing the head keeps out_ctrl inert while the stage is empty.
        head_r <= {ENT_W{1'b0}};
        skid_r <= {ENT_W{1'b0}};
      end else begin
        case (state_r)
          EMPTY: begin
            if (accept_s) head_r <= in_entry_s;
            else          head_r <= head_r;
          end
          ONE: begin
            if (accept_s && pop_s) head_r <= in_entry_s;
            else if (accept_s)     skid_r <= in_entry_s;
            else                   head_r <= head_r;
          end
          FULL: begin
            if (pop_s) head_r <= skid_r;
            else       head_r <= head_r;
          end
          default: begin
            head_r <= {ENT_W{1'b0}};
            skid_r <= {ENT_W{1'b0}};
          end
        endcase
      end
      branch_taken <= br_fire_s;
      if (br_fire_s) branch_target <= in_branch_target;
      else           branch_target <= branch_target;
    end
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory boundary register placed directly downstream of the 32-bit ALU.
- Captures the ALU result, the zero flag, the destination register, the store data and the memory/writeback control bits, then presents them to the data-cache/memory stage through a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so cache stalls never create a combinational ready path back into execute.
- Also resolves beq branches from the ALU zero flag.

Parameters:
- DATA_W, 32, width of the ALU result and store data.
- REG_ADDR_W, 5, width of the destination register index.
- CTRL_W, 4, control bundle width; bit0 mem_read, bit1 mem_write, bit2 reg_write, bit3 mem_to_reg.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage holds a valid op.
- in_ready  out  1  stage can accept; registered.
- alu_result  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero flag.
- in_rd  in  REG_ADDR_W  destination register.
- in_store_data  in  DATA_W  rt value used for stores.
- in_ctrl  in  CTRL_W  control bundle.
- in_is_branch  in  1  op is a beq.
- in_branch_target  in  DATA_W  computed target of the branch.
- flush  in  1  kill all buffered entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts the head entry.
- out_result, out_zero, out_rd, out_store_data, out_ctrl  out  head entry fields; widths match the corresponding inputs.
- branch_taken  out  1  one-cycle pulse.
- branch_target  out  DATA_W  valid while branch_taken is 1.

Behaviour:
- Reset: rst=1 clears all state immediately and asynchronously.
  - out_valid=0, in_ready=1, branch_taken=0.
  - All data outputs are 0, including out_ctrl, so no spurious write can occur.
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Once out_valid=1, the head fields stay stable until pop.
- State machine: EMPTY, ONE, FULL. Head register drives the outputs; the skid register holds the second entry.
  - EMPTY: accept -> ONE, head loaded.
  - ONE, accept without pop -> FULL, skid loaded.
  - ONE, pop without accept -> EMPTY.
  - ONE, accept with pop -> ONE, head loaded with the new entry.
  - FULL: in_ready=0, no accept. pop -> ONE, skid moves to head.
- in_ready is a register equal to (next state != FULL).
- Latency: accepted in cycle N gives out_valid in cycle N+1 when the stage was EMPTY.
- Ordering: strict FIFO, no reordering.
- Throughput: one op per cycle while out_ready=1.
- Branch resolution: on accept with in_is_branch=1 and alu_zero=1:
  - branch_taken=1 for exactly the next cycle, with branch_target = captured in_branch_target.
  - This is independent of downstream stalls.
  - A branch with zero=0 produces no pulse.
- Flush:
  - At the next edge, state -> EMPTY, out_valid=0, in_ready=1.
  - Any input presented in the flush cycle is dropped; its branch pulse is suppressed.
  - An already-scheduled branch_taken pulse from the previous accept still fires.
- Simultaneous flush and pop: the pop completes downstream; the stage still ends EMPTY.
- Reset mid-operation drops all entries with no partial output.
- No arithmetic is performed; fields pass bit-exact.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- When defined, three extra outputs are added:
  - fwd_valid (1): out_valid & out_ctrl[2] & (out_rd != 0).
  - fwd_rd (REG_ADDR_W): equals out_rd.
  - fwd_data (DATA_W): equals out_result.
- These feed the execute-stage forwarding mux; they are combinational from the head register, add no latency, and are 0 on reset.
- When not defined, these ports and their logic are absent; everything else is identical.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_ctrl=0, branch_taken=0.
- Single op: alu_result=0x0000_0005, in_rd=3, in_ctrl=4'b0100, with out_ready=1 -> out_valid=1 one cycle later with identical fields; pops next cycle -> EMPTY.
- Backpressure:
  - Hold out_ready=0 and send ops A=0x11 and B=0x22 -> after B, in_ready=0 and C is held off.
  - Raise out_ready -> A, B, C emerge in order; in_ready is 1 the cycle after the first pop.
- Branch:
  - Accept in_is_branch=1, alu_zero=1, in_branch_target=0x0000_0040 -> branch_taken=1 for one cycle with target 0x40.
  - Same op with alu_zero=0 -> no pulse.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flush-cycle input never appears at the output.
- Streaming: 8 back-to-back ops with out_ready=1 throughout -> 8 consecutive output cycles, in_ready never drops.
- EX_MEM_FWD_EN build: head with rd=0 and reg_write=1 -> fwd_valid=0; rd=7 -> fwd_valid=1, fwd_data=out_result.
